// File: rtl/strhw_common_types.sv
// Shared Streebog types, digest IVs and the final-block padding helper.
package strhw_common_types;

  typedef logic [511:0] uint512;

  // g_N status as seen by the scheduler.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam uint512 IV_512 = '0;
  localparam uint512 IV_256 = {64{8'h01}};

  // Keep the low len bits of data and put a single 1 just above them.
  // A full 512-bit block passes through unchanged.
  function automatic uint512 strhw_pad(input uint512 data, input logic [9:0] len);
    uint512 one;
    uint512 mask;
    if (len >= 10'd512) begin
      return data;
    end
    one  = uint512'(1) << len;
    mask = one - uint512'(1);
    return (data & mask) | one;
  endfunction

endpackage

// File: rtl/strhw_msg_sched.sv
// Streebog message scheduler: takes message blocks, pads the last one, runs g_N over
// every block plus the two finalisation passes, and keeps h, N and Sigma.
module strhw_msg_sched
  import strhw_common_types::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         mode_256_i,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [511:0] blk_data_i,
  input  logic [9:0]   blk_len_i,
  input  logic         blk_last_i,
  output logic         gn_trg_o,
  output logic [511:0] gn_m_o,
  output logic [511:0] gn_n_o,
  output logic [511:0] gn_h_o,
  input  logic [511:0] gn_result_i,
  input  state_t       gn_state_i,
  output logic [511:0] hash_o,
  output logic         done_o,
  output logic         busy_o
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitBlk,
    StTrg,
    StWaitBusy,
    StWaitDone,
    StUpd,
    StDone
  } sched_st_e;

  typedef enum logic [1:0] {
    PhMsg,
    PhFinN,
    PhFinS
  } phase_e;

  sched_st_e r_state, w_state_d;
  phase_e    r_phase, w_phase_d;

  uint512     r_h, w_h_d;
  uint512     r_n, w_n_d;
  uint512     r_sigma, w_sigma_d;
  uint512     r_m, w_m_d;
  uint512     r_hash, w_hash_d;
  logic [9:0] r_len, w_len_d;
  logic       r_last, w_last_d;
  logic       r_pad_done, w_pad_done_d;
  logic       r_done, w_done_d;

  uint512     w_n_sum;
  uint512     w_sigma_sum;
  logic [9:0] w_blk_len;

  // FSM state register; reset aborts any pass in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_phase <= PhMsg;
    end else begin
      r_state <= w_state_d;
      r_phase <= w_phase_d;
    end
  end

  // Chaining value, counters, current m operand and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_h        <= '0;
      r_n        <= '0;
      r_sigma    <= '0;
      r_m        <= '0;
      r_hash     <= '0;
      r_len      <= '0;
      r_last     <= 1'b0;
      r_pad_done <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_h        <= w_h_d;
      r_n        <= w_n_d;
      r_sigma    <= w_sigma_d;
      r_m        <= w_m_d;
      r_hash     <= w_hash_d;
      r_len      <= w_len_d;
      r_last     <= w_last_d;
      r_pad_done <= w_pad_done_d;
      r_done     <= w_done_d;
    end
  end

  // Next-state and datapath updates; N and Sigma wrap mod 2^512.
  always_comb begin
    w_state_d    = r_state;
    w_phase_d    = r_phase;
    w_h_d        = r_h;
    w_n_d        = r_n;
    w_sigma_d    = r_sigma;
    w_m_d        = r_m;
    w_hash_d     = r_hash;
    w_len_d      = r_len;
    w_last_d     = r_last;
    w_pad_done_d = r_pad_done;
    w_done_d     = r_done;

    w_n_sum     = r_n + uint512'(r_len);
    w_sigma_sum = r_sigma + r_m;
    // Length only matters on the last block; oversize lengths clamp to a full block.
    if (blk_last_i && (blk_len_i < 10'd512)) begin
      w_blk_len = blk_len_i;
    end else begin
      w_blk_len = 10'd512;
    end

    unique case (r_state)
      StIdle, StDone: begin
        if (start_i) begin
          w_h_d        = mode_256_i ? IV_256 : IV_512;
          w_n_d        = '0;
          w_sigma_d    = '0;
          w_done_d     = 1'b0;
          w_phase_d    = PhMsg;
          w_pad_done_d = 1'b0;
          w_last_d     = 1'b0;
          w_state_d    = StWaitBlk;
        end
      end
      StWaitBlk: begin
        if (blk_valid_i) begin
          w_last_d  = blk_last_i;
          w_len_d   = w_blk_len;
          w_m_d     = strhw_pad(blk_data_i, w_blk_len);
          w_state_d = StTrg;
        end
      end
      StTrg: begin
        w_state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (gn_state_i == BUSY) begin
          w_state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        // g_N still reports DONE from the previous pass until it has gone BUSY.
        if (gn_state_i == DONE) begin
          w_state_d = StUpd;
        end
      end
      StUpd: begin
        w_h_d     = gn_result_i;
        w_state_d = StTrg;
        unique case (r_phase)
          PhMsg: begin
            w_n_d     = w_n_sum;
            w_sigma_d = w_sigma_sum;
            if (!r_last) begin
              w_state_d = StWaitBlk;
            end else if ((r_len == 10'd512) && !r_pad_done) begin
              // A full final block leaves no room for the pad bit: add an empty block.
              w_m_d        = uint512'(1);
              w_len_d      = '0;
              w_pad_done_d = 1'b1;
            end else begin
              w_phase_d = PhFinN;
              w_m_d     = w_n_sum;
            end
          end
          PhFinN: begin
            w_phase_d = PhFinS;
            w_m_d     = r_sigma;
          end
          PhFinS: begin
            w_hash_d  = gn_result_i;
            w_done_d  = 1'b1;
            w_state_d = StDone;
          end
          default: begin
            w_state_d = StIdle;
          end
        endcase
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Operands come straight from registers that only move outside a g_N pass.
  always_comb begin
    blk_ready_o = (r_state == StWaitBlk);
    gn_trg_o    = (r_state == StTrg);
    gn_m_o      = r_m;
    gn_n_o      = (r_phase == PhMsg) ? r_n : '0;
    gn_h_o      = r_h;
    hash_o      = r_hash;
    done_o      = r_done;
    busy_o      = (r_state != StIdle) && (r_state != StDone);
  end

endmodule

// File: tb/tb_strhw_msg_sched.sv
// Directed bench for strhw_msg_sched against a simple behavioural g_N stand-in.
module tb_strhw_msg_sched;
  import strhw_common_types::*;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic         mode_256_i = 1'b0;
  logic         blk_valid_i = 1'b1;
  logic         blk_ready_o;
  logic [511:0] blk_data_i = '0;
  logic [9:0]   blk_len_i = '0;
  logic         blk_last_i = 1'b0;
  logic         gn_trg_o;
  logic [511:0] gn_m_o, gn_n_o, gn_h_o;
  logic [511:0] gn_result_i;
  state_t       gn_state_i;
  logic [511:0] hash_o;
  logic         done_o, busy_o;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk_i = ~clk_i;

  strhw_msg_sched u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .mode_256_i  (mode_256_i),
    .blk_valid_i (blk_valid_i),
    .blk_ready_o (blk_ready_o),
    .blk_data_i  (blk_data_i),
    .blk_len_i   (blk_len_i),
    .blk_last_i  (blk_last_i),
    .gn_trg_o    (gn_trg_o),
    .gn_m_o      (gn_m_o),
    .gn_n_o      (gn_n_o),
    .gn_h_o      (gn_h_o),
    .gn_result_i (gn_result_i),
    .gn_state_i  (gn_state_i),
    .hash_o      (hash_o),
    .done_o      (done_o),
    .busy_o      (busy_o)
  );

  // Stand-in compression: cheap but sensitive to every operand bit.
  function automatic logic [511:0] gn_f(input logic [511:0] h, input logic [511:0] m,
                                        input logic [511:0] n);
    return ({h[510:0], h[511]} ^ m) + n + 512'd7;
  endfunction

  // g_N stand-in: BUSY the cycle after a trigger, DONE four cycles later.
  logic         log_clr = 1'b0;
  logic [3:0]   trg_cnt;
  logic [511:0] log_m [8];
  logic [511:0] log_n [8];
  logic [511:0] cap_m, cap_n, cap_h;
  logic [2:0]   gn_cnt;
  logic         trg_prev;
  int           stab_err, wid_err, acc_cnt;

  always @(posedge clk_i) begin
    if (rst_i) begin
      gn_state_i  <= CLEAR;
      gn_result_i <= '0;
      gn_cnt      <= '0;
    end else if (gn_trg_o) begin
      gn_state_i <= BUSY;
      gn_cnt     <= 3'd3;
      cap_m      <= gn_m_o;
      cap_n      <= gn_n_o;
      cap_h      <= gn_h_o;
    end else if (gn_state_i == BUSY) begin
      if (gn_cnt == 3'd0) begin
        gn_state_i  <= DONE;
        gn_result_i <= gn_f(cap_h, cap_m, cap_n);
      end else begin
        gn_cnt <= gn_cnt - 3'd1;
      end
    end
  end

  always @(posedge clk_i) begin
    trg_prev <= gn_trg_o;
    if (rst_i || log_clr) begin
      trg_cnt  <= '0;
      stab_err <= 0;
      wid_err  <= 0;
      acc_cnt  <= 0;
    end else begin
      if (gn_trg_o) begin
        log_m[trg_cnt[2:0]] <= gn_m_o;
        log_n[trg_cnt[2:0]] <= gn_n_o;
        trg_cnt <= trg_cnt + 4'd1;
      end
      if (gn_trg_o && trg_prev) wid_err <= wid_err + 1;
      if ((gn_state_i == BUSY) && !gn_trg_o &&
          ((gn_m_o != cap_m) || (gn_n_o != cap_n) || (gn_h_o != cap_h)))
        stab_err <= stab_err + 1;
      if (blk_valid_i && blk_ready_o) acc_cnt <= acc_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference digest for one or two blocks through the stand-in g_N.
  function automatic logic [511:0] model_hash(input logic m256, input int nblk,
                                              input logic [511:0] d0, input logic [511:0] d1,
                                              input logic [9:0] lastlen);
    logic [511:0] h, n, s, m, d;
    int len;
    h   = m256 ? {64{8'h01}} : '0;
    n   = '0;
    s   = '0;
    len = 512;
    for (int i = 0; i < nblk; i++) begin
      d   = (i == 0) ? d0 : d1;
      len = (i == nblk - 1) ? ((lastlen > 10'd512) ? 512 : int'(lastlen)) : 512;
      if (len < 512) m = (d & ((512'd1 << len) - 512'd1)) | (512'd1 << len);
      else m = d;
      h = gn_f(h, m, n);
      n = n + 512'(len);
      s = s + m;
    end
    if (len == 512) begin
      h = gn_f(h, 512'd1, n);
      s = s + 512'd1;
    end
    h = gn_f(h, n, '0);
    h = gn_f(h, s, '0);
    return h;
  endfunction

  task automatic run_msg(input string tag, input logic m256, input int nblk,
                         input logic [511:0] d0, input logic [511:0] d1,
                         input logic [9:0] lastlen, input logic poke);
    bit got;
    log_clr = 1'b1;
    @(posedge clk_i); #1;
    log_clr    = 1'b0;
    blk_data_i = d0;
    blk_last_i = (nblk == 1);
    blk_len_i  = (nblk == 1) ? lastlen : 10'd100;
    mode_256_i = m256;
    start_i    = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int i = 0; i < nblk; i++) begin
      if (i > 0) begin
        blk_data_i = d1;
        blk_last_i = (i == nblk - 1);
        blk_len_i  = lastlen;
      end
      got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
        if (blk_ready_o) got = 1'b1;
        else begin
          @(posedge clk_i); #1;
        end
      end
      check({tag, " blk_accept"}, 512'(got), 512'd1);
      if (!got) return;
      @(posedge clk_i); #1;
      if (i == 0 && poke) begin
        // Start while busy with the other IV must be ignored.
        start_i    = 1'b1;
        mode_256_i = ~m256;
        @(posedge clk_i); #1;
        start_i    = 1'b0;
        mode_256_i = m256;
      end
    end
    for (int c = 0; c < 400 && !done_o; c++) begin
      @(posedge clk_i); #1;
    end
    check({tag, " done"}, 512'(done_o), 512'd1);
    check({tag, " busy"}, 512'(busy_o), 512'd0);
    check({tag, " hash"}, hash_o, model_hash(m256, nblk, d0, d1, lastlen));
    check({tag, " accepted"}, 512'(acc_cnt), 512'(nblk));
    check({tag, " trg_width"}, 512'(wid_err), 512'd0);
    check({tag, " stable"}, 512'(stab_err), 512'd0);
  endtask

  initial begin
    logic [511:0] d1v, d2v;
    bit got;
    d1v = {16{32'hA5C3_0F17}};
    d2v = {8{64'h0123_4567_89AB_CDEF}};

    repeat (3) @(posedge clk_i);
    #1;
    check("rst ready", 512'(blk_ready_o), 512'd0);
    check("rst busy", 512'(busy_o), 512'd0);
    check("rst done", 512'(done_o), 512'd0);
    check("rst trg", 512'(gn_trg_o), 512'd0);
    check("rst hash", hash_o, '0);
    check("rst gn_m", gn_m_o, '0);
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("idle ready", 512'(blk_ready_o), 512'd0);

    // Empty message: m=1, N stays 0, Sigma=1.
    run_msg("empty", 1'b0, 1, d2v, '0, 10'd0, 1'b0);
    check("empty trgs", 512'(trg_cnt), 512'd3);
    check("empty m0", log_m[0], 512'd1);
    check("empty n0", log_n[0], 512'd0);
    check("empty N", log_m[1], 512'd0);
    check("empty Sigma", log_m[2], 512'd1);

    // 504-bit message, both IVs; top byte replaced by the pad bit.
    run_msg("m504", 1'b0, 1, d1v, '0, 10'd504, 1'b0);
    check("m504 trgs", 512'(trg_cnt), 512'd3);
    check("m504 m0", log_m[0], {8'h01, d1v[503:0]});
    check("m504 N", log_m[1], 512'h1F8);
    check("m504 fin n", log_n[1], 512'd0);
    run_msg("m504_256", 1'b1, 1, d1v, '0, 10'd504, 1'b0);
    check("m504_256 h0", log_n[0], 512'd0);

    // 576 bits: full block then 64-bit tail.
    run_msg("m576", 1'b0, 2, d1v, d2v, 10'd64, 1'b0);
    check("m576 trgs", 512'(trg_cnt), 512'd4);
    check("m576 n1", log_n[1], 512'd512);
    check("m576 m1", log_m[1], {447'd0, 1'b1, 64'h0123_4567_89AB_CDEF});
    check("m576 N", log_m[2], 512'h240);

    // Exact 512-bit message: extra pad pass with m=1.
    run_msg("m512", 1'b0, 1, d2v, '0, 10'd512, 1'b0);
    check("m512 trgs", 512'(trg_cnt), 512'd4);
    check("m512 pad m", log_m[1], 512'd1);
    check("m512 pad n", log_n[1], 512'd512);
    check("m512 N", log_m[2], 512'd512);
    check("m512 Sigma", log_m[3], d2v + 512'd1);

    // Oversize length clamps to a full block.
    run_msg("clamp", 1'b0, 1, d1v, '0, 10'd1000, 1'b0);
    check("clamp trgs", 512'(trg_cnt), 512'd4);
    check("clamp N", log_m[2], 512'd512);
    check("clamp Sigma", log_m[3], d1v + 512'd1);

    // Reset while waiting on g_N: outputs drop without a clock edge.
    log_clr = 1'b1;
    @(posedge clk_i); #1;
    log_clr    = 1'b0;
    blk_data_i = d1v;
    blk_last_i = 1'b1;
    blk_len_i  = 10'd504;
    start_i    = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      if (gn_state_i == BUSY) got = 1'b1;
      else begin
        @(posedge clk_i); #1;
      end
    end
    check("abort reach busy", 512'(got), 512'd1);
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    #1;
    check("abort busy", 512'(busy_o), 512'd0);
    check("abort trg", 512'(gn_trg_o), 512'd0);
    check("abort ready", 512'(blk_ready_o), 512'd0);
    check("abort gn_m", gn_m_o, '0);
    check("abort gn_h", gn_h_o, '0);
    check("abort hash", hash_o, '0);
    check("abort done", 512'(done_o), 512'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Fresh hash after abort, with a stray start pulse mid-run.
    run_msg("post_abort", 1'b1, 2, d2v, d1v, 10'd64, 1'b1);
    check("post_abort trgs", 512'(trg_cnt), 512'd4);
    check("post_abort N", log_m[2], 512'h240);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
